// File: rtl/snn_pkg.sv
// snn_pkg: shared state type and frame geometry for the SNN frame sequencer
package snn_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {LOAD, START, RUN, SETTLE, DONE} seqState;
  function automatic int frameBits(input int words);
    return words * WORD_W;
  endfunction
  function automatic int stepCount(input int words, input int pix);
    return frameBits(words) / pix;
  endfunction
endpackage

// File: rtl/snn_frame_sequencer_if.sv
// snn_frame_sequencer_if: mailbox word channel, network drive/sense and result channel
//   master: mailbox/network/consumer side; slave: the sequencer
interface snn_frame_sequencer_if #(parameter int PIX = 7);
  logic iWORD_VALID;
  logic [snn_pkg::WORD_W-1:0] iWORD_DATA;
  logic oWORD_READY;
  logic iABORT;
  logic oSNN_START;
  logic oSNN_EN;
  logic [PIX-1:0] oSNN_PIXELS;
  logic [1:0] iSNN_OUT;
  logic [1:0] oRESULT;
  logic oRESULT_VALID;
  logic iRESULT_ACK;
  modport master(output iWORD_VALID, iWORD_DATA, iABORT, iSNN_OUT, iRESULT_ACK,
                 input oWORD_READY, oSNN_START, oSNN_EN, oSNN_PIXELS, oRESULT, oRESULT_VALID);
  modport slave(input iWORD_VALID, iWORD_DATA, iABORT, iSNN_OUT, iRESULT_ACK,
                output oWORD_READY, oSNN_START, oSNN_EN, oSNN_PIXELS, oRESULT, oRESULT_VALID);
endinterface

// File: rtl/snn_frame_buffer.sv
// snn_frame_buffer: WORDS x 32 frame store with a registered PIX-bit slice read at bit PIX*rdIdx
//   we/wIdx/wData: word write port; rdEn/rdIdx: slice select (rdEn=0 loads zero); rdData: slice
module snn_frame_buffer import snn_pkg::*; #(
  parameter int WORDS = 25,
  parameter int PIX = 7,
  localparam int STEPS = stepCount(WORDS, PIX),
  localparam int WCW = $clog2(WORDS + 1),
  localparam int SCW = $clog2(STEPS + 1)
) (
  input logic iCLK,
  input logic iRESETn,
  input logic we,
  input logic [WCW-1:0] wIdx,
  input logic [WORD_W-1:0] wData,
  input logic rdEn,
  input logic [SCW-1:0] rdIdx,
  output logic [PIX-1:0] rdData
);
  localparam int FB = frameBits(WORDS);
  localparam int OW = $clog2(FB);
  logic [WORD_W-1:0] mem [WORDS];
  logic [FB-1:0] flat;
  logic [OW-1:0] off;
  for (genvar k = 0; k < WORDS; k++) assign flat[k*WORD_W +: WORD_W] = mem[k];
  assign off = OW'(PIX * rdIdx);
  always_ff @(posedge iCLK)
    if (we) mem[wIdx] <= wData;
  always_ff @(posedge iCLK)
    if (!iRESETn) rdData <= '0;
    else rdData <= rdEn ? flat[off +: PIX] : '0;
endmodule

// File: rtl/snn_frame_sequencer.sv
// snn_frame_sequencer: buffers a mailbox frame, streams it into the spiking network, latches the result
//   iCLK/iRESETn: clock, sync active-low reset; bus: word, network and result channels
//   oBUSY: state is not LOAD; oFRAME_CNT: acknowledged frames (wraps)
module snn_frame_sequencer import snn_pkg::*; #(
  parameter int WORDS = 25,
  parameter int PIX = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input logic iCLK,
  input logic iRESETn,
  snn_frame_sequencer_if.slave bus,
  output logic oBUSY,
  output logic [15:0] oFRAME_CNT
);
  localparam int STEPS = stepCount(WORDS, PIX);
  localparam int WCW = $clog2(WORDS + 1);
  localparam int SCW = $clog2(STEPS + 1);
  localparam int TCW = SETTLE_CYCLES == 0 ? 1 : $clog2(SETTLE_CYCLES + 1);
  seqState state, nextState;
  logic [WCW-1:0] wordCnt;
  logic [SCW-1:0] stepCnt;
  logic [TCW-1:0] settleCnt;
  logic [15:0] frameCnt;
  logic accept, ack, capture;
  assign bus.oWORD_READY = state == LOAD && !bus.iABORT;
  assign accept = bus.iWORD_VALID && bus.oWORD_READY;
  assign ack = bus.iRESULT_ACK && bus.oRESULT_VALID;
  assign capture = nextState == DONE && state != DONE;
  assign oFRAME_CNT = frameCnt;
  always_comb begin
    nextState = state;
    if (bus.iABORT) nextState = LOAD;
    else case (state)
      LOAD: if (accept && wordCnt == WCW'(WORDS - 1)) nextState = START;
      START: nextState = RUN;
      RUN: if (stepCnt == SCW'(STEPS - 1)) nextState = SETTLE_CYCLES == 0 ? DONE : SETTLE;
      SETTLE: if (settleCnt == TCW'(SETTLE_CYCLES - 1)) nextState = DONE;
      DONE: if (ack) nextState = LOAD;
      default: nextState = LOAD;
    endcase
  end
  always_ff @(posedge iCLK)
    if (!iRESETn) state <= LOAD;
    else state <= nextState;
  // Network outputs are registered from nextState so EN and the pixel slice move together.
  always_ff @(posedge iCLK)
    if (!iRESETn) begin
      wordCnt <= '0;
      stepCnt <= '0;
      settleCnt <= '0;
      bus.oSNN_START <= 1'b0;
      bus.oSNN_EN <= 1'b0;
      bus.oRESULT <= '0;
      bus.oRESULT_VALID <= 1'b0;
      oBUSY <= 1'b0;
      frameCnt <= '0;
    end else begin
      wordCnt <= bus.iABORT || nextState != LOAD ? '0 : accept ? wordCnt + 1'b1 : wordCnt;
      stepCnt <= state == RUN && nextState == RUN ? stepCnt + 1'b1 : '0;
      settleCnt <= state == SETTLE && nextState == SETTLE ? settleCnt + 1'b1 : '0;
      bus.oSNN_START <= nextState == START;
      bus.oSNN_EN <= nextState == RUN || nextState == SETTLE;
      if (capture) bus.oRESULT <= bus.iSNN_OUT;
      bus.oRESULT_VALID <= capture || (bus.oRESULT_VALID && !ack && !bus.iABORT);
      oBUSY <= nextState != LOAD;
      frameCnt <= frameCnt + 16'(ack && !bus.iABORT);
    end
  // Slice for the step shown next cycle: 0 when entering RUN, otherwise one ahead of stepCnt.
  snn_frame_buffer #(.WORDS(WORDS), .PIX(PIX)) buffer (
    .iCLK(iCLK),
    .iRESETn(iRESETn),
    .we(accept),
    .wIdx(wordCnt),
    .wData(bus.iWORD_DATA),
    .rdEn(nextState == RUN),
    .rdIdx(state == RUN ? stepCnt + 1'b1 : '0),
    .rdData(bus.oSNN_PIXELS)
  );
endmodule
